// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, default arbitration limits and state/owner encodings for the
// memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE           = 16;
  localparam int MAX_DATA_STREAK_DEF = 4;
  localparam int TIMEOUT_DEF         = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Bits needed to hold a counter that runs from 0 up to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: strobes, address and write data out,
// read data and the two completion acknowledges back.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = WORD_SIZE
) ();

  logic         readM;
  logic         writeM;
  logic [W-1:0] address;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic         inputReady;
  logic         ackOutput;

  modport master (
    output readM, writeM, address, mem_wdata,
    input  mem_rdata, inputReady, ackOutput
  );

  modport slave (
    input  readM, writeM, address, mem_wdata,
    output mem_rdata, inputReady, ackOutput
  );

endinterface

// File: rtl/mem_port_arbiter_streak_picker.sv
// Grant decision between fetch and data, plus the contended-data streak
// counter that forces fetch through after too many data wins in a row.
module arb_streak_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic clk,
  input  logic Reset,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_strobe,
  output logic grant_d
);

  localparam int SW = cnt_width(MAX_DATA_STREAK);

  logic [SW-1:0] streak_reg;
  logic [SW-1:0] streak_next;
  logic          streak_full;

  assign streak_full = (streak_reg == SW'(MAX_DATA_STREAK));
  assign grant_d     = d_req && !(i_req && streak_full);

  // Only contended data wins count; any fetch win restarts the streak.
  always_comb begin
    streak_next = streak_reg;
    if (grant_strobe) begin
      if (!grant_d) begin
        streak_next = '0;
      end else if (i_req && !streak_full) begin
        streak_next = streak_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access:
// IDLE picks an owner, BUSY drives the strobes until acknowledge or timeout, RESP pulses ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF,
  parameter int TIMEOUT         = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic [WORD_SIZE-1:0] i_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [WORD_SIZE-1:0] d_rdata,
  mem_port_arbiter_if.master   mem,
  output logic                 bus_err,
  output logic                 busy
);

  localparam int TW = cnt_width(TIMEOUT);

  arb_state_t           state_reg, state_next;
  owner_t               owner_reg, owner_next;
  logic                 we_reg, we_next;
  logic [WORD_SIZE-1:0] addr_reg, addr_next;
  logic [WORD_SIZE-1:0] wdata_reg, wdata_next;
  logic                 read_reg, read_next;
  logic                 write_reg, write_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic                 i_ready_reg, i_ready_next;
  logic                 d_ready_reg, d_ready_next;
  logic                 err_reg, err_next;
  logic                 busy_reg, busy_next;
  logic [WORD_SIZE-1:0] i_data_reg, i_data_next;
  logic [WORD_SIZE-1:0] d_rdata_reg, d_rdata_next;

  logic                 grant_strobe;
  logic                 grant_d;
  logic                 done;
  logic                 timed_out;
  logic [WORD_SIZE-1:0] captured;

  arb_streak_picker #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_picker (
    .clk         (clk),
    .Reset       (Reset),
    .i_req       (i_req),
    .d_req       (d_req),
    .grant_strobe(grant_strobe),
    .grant_d     (grant_d)
  );

  // Only the acknowledge matching the transaction direction counts.
  assign done      = we_reg ? mem.ackOutput : mem.inputReady;
  assign timed_out = (timer_reg == TW'(TIMEOUT - 1));
  assign captured  = done ? mem.mem_rdata : '0;

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    read_next    = read_reg;
    write_next   = write_reg;
    timer_next   = timer_reg;
    i_ready_next = 1'b0;
    d_ready_next = 1'b0;
    err_next     = 1'b0;
    busy_next    = busy_reg;
    i_data_next  = i_data_reg;
    d_rdata_next = d_rdata_reg;
    grant_strobe = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          grant_strobe = 1'b1;
          if (grant_d) begin
            owner_next = OWN_D;
            we_next    = d_we;
            addr_next  = d_addr;
            wdata_next = d_wdata;
          end else begin
            owner_next = OWN_I;
            we_next    = 1'b0;
            addr_next  = i_addr;
          end
          read_next  = grant_d ? !d_we : 1'b1;
          write_next = grant_d ? d_we : 1'b0;
          timer_next = '0;
          busy_next  = 1'b1;
          state_next = BUSY;
        end
      end

      BUSY: begin
        if (done || timed_out) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          err_next   = !done;
          state_next = RESP;
          if (owner_reg == OWN_D) begin
            d_ready_next = 1'b1;
            if (!we_reg) begin
              d_rdata_next = captured;
            end
          end else begin
            i_ready_next = 1'b1;
            i_data_next  = captured;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      RESP: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      owner_reg   <= OWN_I;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      read_reg    <= 1'b0;
      write_reg   <= 1'b0;
      timer_reg   <= '0;
      i_ready_reg <= 1'b0;
      d_ready_reg <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      i_data_reg  <= '0;
      d_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      read_reg    <= read_next;
      write_reg   <= write_next;
      timer_reg   <= timer_next;
      i_ready_reg <= i_ready_next;
      d_ready_reg <= d_ready_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
      i_data_reg  <= i_data_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

  assign mem.readM     = read_reg;
  assign mem.writeM    = write_reg;
  assign mem.address   = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign i_ready       = i_ready_reg;
  assign d_ready       = d_ready_reg;
  assign i_data        = i_data_reg;
  assign d_rdata       = d_rdata_reg;
  assign bus_err       = err_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-programmable memory model, a vector
// table, arbitration/reset sequences and a randomized run against a transaction model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        Reset;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_ready, d_ready, bus_err, busy;
  logic [15:0] i_data, d_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk    (clk),
    .Reset  (Reset),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_ready(i_ready),
    .i_data (i_data),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_rdata(d_rdata),
    .mem    (bus),
    .bus_err(bus_err),
    .busy   (busy)
  );

  // Memory: answers in the strobe cycle numbered mem_lat (0 = never answers).
  logic [15:0] mem [0:255];
  int mem_lat   = 1;
  int glitch_at = 0;
  int scnt      = 0;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'hC000 | 16'(a);
    mem[8'h10]     = 16'h1234;
    bus.inputReady = 1'b0;
    bus.ackOutput  = 1'b0;
    bus.mem_rdata  = 16'hDEAD;
  end

  always begin
    @(posedge clk);
    #1;
    if (bus.readM || bus.writeM) scnt++;
    else scnt = 0;
    bus.inputReady = bus.readM && (scnt == mem_lat);
    bus.ackOutput  = (bus.writeM && (scnt == mem_lat)) ||
                     (bus.readM && glitch_at != 0 && scnt == glitch_at);
    bus.mem_rdata  = bus.inputReady ? mem[bus.address[7:0]] : 16'hDEAD;
    if (bus.writeM && bus.ackOutput) mem[bus.address[7:0]] = bus.mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Follows one transaction up to and including its ready pulse.
  task automatic expect_txn(input string name, input bit exp_d, input bit exp_we,
                            input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                            input int exp_strobes, input logic [15:0] exp_data,
                            input bit exp_err, input int exp_cycles);
    int strobes = 0;
    int cycles  = 0;
    bit seen    = 0;
    bit bad_bus = 0;
    bit bad_err = 0;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (bus.readM || bus.writeM) begin
        strobes++;
        if (bus.readM && bus.writeM) bad_bus = 1;
        if (bus.writeM !== exp_we || bus.address !== exp_addr || busy !== 1'b1) bad_bus = 1;
        if (exp_we && bus.mem_wdata !== exp_wdata) bad_bus = 1;
      end
      if (i_ready || d_ready) seen = 1;
      else if (bus_err) bad_err = 1;
    end
    check({name, "/ready_seen"}, 32'(seen), 32'd1);
    check({name, "/owner"}, 32'({i_ready, d_ready}), 32'({!exp_d, exp_d}));
    check({name, "/strobe_cycles"}, 32'(strobes), 32'(exp_strobes));
    check({name, "/bus_ok"}, 32'({bad_bus, bad_err}), 32'd0);
    check({name, "/bus_err"}, 32'(bus_err), 32'(exp_err));
    check({name, "/data"}, 32'(exp_d ? d_rdata : i_data), 32'(exp_data));
    if (exp_cycles > 0) check({name, "/latency"}, 32'(cycles), 32'(exp_cycles));
    $display("txn %s: owner=%s we=%0b addr=%h strobes=%0d data=%h err=%0b cycles=%0d",
             name, d_ready ? "D" : "I", exp_we, exp_addr, strobes,
             exp_d ? d_rdata : i_data, bus_err, cycles);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          glitch;
    logic [15:0] exp_data;
    bit          exp_err;
    int          exp_strobes;
  } vec_t;

  vec_t vecs[10];
  int   ord[10];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   streak_m;
    bit   i_pend, d_pend, win_d, ok;
    int   lat;
    logic [15:0] exp_i, exp_dr;

    vecs[0] = '{0, 0, 16'h0010, 16'h0000, 2, 0, 16'h1234, 0, 2};
    vecs[1] = '{1, 1, 16'h0020, 16'hBEEF, 1, 0, 16'h0000, 0, 1};
    vecs[2] = '{1, 0, 16'h0020, 16'h0000, 1, 0, 16'hBEEF, 0, 1};
    vecs[3] = '{0, 0, 16'h0033, 16'h0000, 3, 0, 16'hC033, 0, 3};
    vecs[4] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1, 15};
    vecs[5] = '{1, 0, 16'h0041, 16'h0000, 3, 1, 16'hC041, 0, 3};
    vecs[6] = '{0, 0, 16'h0055, 16'h0000, 0, 0, 16'h0000, 1, 15};
    vecs[7] = '{1, 1, 16'h0060, 16'h1234, 4, 0, 16'hC041, 0, 4};
    vecs[8] = '{1, 1, 16'h0061, 16'h5555, 0, 0, 16'hC041, 1, 15};
    vecs[9] = '{1, 0, 16'h0060, 16'h0000, 1, 0, 16'h1234, 0, 1};
    ord     = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    Reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 16'h00FF; d_addr = 16'h00FF; d_wdata = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("reset/flags", 32'({i_ready, d_ready, bus_err, busy, bus.readM, bus.writeM}), 32'd0);
    check("reset/data", 32'({i_data, d_rdata}), 32'd0);
    check("reset/bus", 32'({bus.address, bus.mem_wdata}), 32'd0);
    Reset = 1'b0;

    // Vector table; the first request lands in IDLE, later ones during RESP.
    for (int i = 0; i < 10; i++) begin
      mem_lat   = vecs[i].lat;
      glitch_at = vecs[i].glitch;
      if (vecs[i].is_d) begin
        d_req = 1; d_we = vecs[i].we; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      end else begin
        i_req = 1; i_addr = vecs[i].addr;
      end
      expect_txn($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].we, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_strobes, vecs[i].exp_data, vecs[i].exp_err,
                 vecs[i].exp_strobes + ((i == 0) ? 1 : 2));
      i_req = 0; d_req = 0;
    end
    glitch_at = 0;

    // Both requesters held continuously: four data wins, then fetch.
    do_reset();
    mem_lat = 1;
    i_req = 1; i_addr = 16'h0070; d_req = 1; d_we = 0; d_addr = 16'h0080;
    for (int k = 0; k < 10; k++)
      expect_txn($sformatf("streak%0d", k), ord[k] == 1, 0,
                 (ord[k] == 1) ? 16'h0080 : 16'h0070, 16'h0000, 1,
                 (ord[k] == 1) ? 16'hC080 : 16'hC070, 0, -1);

    // Reset in the middle of BUSY after building up a streak of three.
    do_reset();
    i_req = 1; d_req = 1; d_we = 0;
    for (int k = 0; k < 3; k++)
      expect_txn($sformatf("pre_rst%0d", k), 1, 0, 16'h0080, 16'h0000, 1, 16'hC080, 0, -1);
    mem_lat = 0;
    repeat (3) @(negedge clk);
    check("mid_busy/readM", 32'(bus.readM), 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    check("rst_busy/flags", 32'({i_ready, d_ready, bus_err, busy, bus.readM, bus.writeM}), 32'd0);
    check("rst_busy/d_rdata", 32'(d_rdata), 32'd0);
    Reset = 1'b0;
    mem_lat = 1;
    for (int k = 0; k < 5; k++)
      expect_txn($sformatf("post_rst%0d", k), ord[k] == 1, 0,
                 (ord[k] == 1) ? 16'h0080 : 16'h0070, 16'h0000, 1,
                 (ord[k] == 1) ? 16'hC080 : 16'hC070, 0, -1);

    // Randomized traffic against a transaction-level model.
    do_reset();
    streak_m = 0; i_pend = 0; d_pend = 0; exp_i = 16'h0000; exp_dr = 16'h0000;
    for (int r = 0; r < 80; r++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1; i_req = 1; i_addr = 16'($urandom_range(0, 255));
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 255)); d_wdata = 16'($urandom);
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1; i_req = 1; i_addr = 16'($urandom_range(0, 255));
      end
      lat     = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      mem_lat = lat;
      ok      = (lat != 0);
      win_d   = d_pend && !(i_pend && streak_m == 4);
      if (win_d && i_pend) streak_m = (streak_m < 4) ? streak_m + 1 : 4;
      else if (!win_d) streak_m = 0;
      if (win_d) begin
        if (!d_we) exp_dr = ok ? mem[d_addr[7:0]] : 16'h0000;
        expect_txn($sformatf("rnd%0d", r), 1, d_we, d_addr, d_wdata, ok ? lat : 15,
                   exp_dr, !ok, -1);
        d_pend = 0; d_req = 0;
      end else begin
        exp_i = ok ? mem[i_addr[7:0]] : 16'h0000;
        expect_txn($sformatf("rnd%0d", r), 0, 0, i_addr, 16'h0000, ok ? lat : 15,
                   exp_i, !ok, -1);
        i_pend = 0; i_req = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single 16-bit memory port of the multicycle CPU between two requesters: instruction fetch (IF state) and data access (LWD/SWD MEM states).
- Drives the memory strobes (readM, writeM, address, write data) and returns read data with a one-cycle ready pulse per requester.
- Gives data priority with anti-starvation for fetch, and a response timeout.

Parameters:
- WORD_SIZE, 16, data/address width; taken from opcodes.v.
- MAX_DATA_STREAK, 4, consecutive contended data grants before fetch is forced through.
- TIMEOUT, 15, BUSY cycles without a memory response before abort.

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request; held until i_ready
- i_addr  in  WORD_SIZE  fetch address
- i_ready  out  1  one-cycle pulse: fetch complete
- i_data  out  WORD_SIZE  fetched word; held until next fetch completion
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  WORD_SIZE  loaded word; held until next data read completion
- readM  out  1  memory read strobe
- writeM  out  1  memory write strobe
- address  out  WORD_SIZE  memory address
- mem_wdata  out  WORD_SIZE  memory write data
- mem_rdata  in  WORD_SIZE  memory read data, valid with inputReady
- inputReady  in  1  memory read done
- ackOutput  in  1  memory write done
- bus_err  out  1  pulses with i_ready/d_ready when the transaction timed out
- busy  out  1  high in BUSY and RESP

Behaviour:
- Reset (sampled at posedge):
  - State goes to IDLE.
  - All outputs are registered and go to 0.
  - Streak and timeout counters clear.
  - An in-flight transaction is dropped with no ready pulse.
- States: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - Evaluates requests.
  - Both requesters high: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
  - On grant: latch owner, we, address and wdata, then go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - Entered with the strobes asserted on the same edge. Read: readM=1. Data write: writeM=1, mem_wdata=d_wdata.
  - address and mem_wdata are held stable for the whole of BUSY.
  - Read completes when inputReady=1. Write completes when ackOutput=1. The mismatched acknowledge is ignored.
  - On completion: strobes drop, mem_rdata is captured into the owner's data register on reads, go to RESP.
  - The timeout counter increments each BUSY cycle. When it reaches TIMEOUT: abort, strobes drop, captured read data = 0, bus_err armed, go to RESP.
- RESP:
  - The owner's ready pulse is high for exactly this cycle. bus_err is high only if aborted.
  - Requests are not evaluated. The next state is IDLE unconditionally.
  - Requesters deassert req the cycle after ready or issue a new one.
- Latency:
  - Request seen in IDLE at cycle N: strobe high from N+1.
  - Memory response at cycle M: ready at M+1.
  - Minimum 3 cycles per transaction with a zero-wait memory.
- Streak counter:
  - Increments (saturating at MAX_DATA_STREAK) on a data grant when i_req is also high.
  - Clears on any fetch grant.
  - Uncontended data grants leave it unchanged.
- A write never updates d_rdata.
- Reads and fetches never assert writeM. readM and writeM are never high together.

Decomposition:
- WORD_SIZE comes from opcodes.v.
- The state encodings (IDLE/BUSY/RESP), owner encoding (OWN_I/OWN_D) and default MAX_DATA_STREAK/TIMEOUT values belong in a shared define file, mem_arb_defs.v.
- One natural sub-module: arb_streak_picker. It contains the streak counter plus the grant decision, has inputs i_req, d_req, grant_strobe and Reset, and outputs grant_d.

Test Plan:
- Fetch only, i_addr=0x0010; memory returns 0x1234 two cycles after readM rises -> readM high 2 cycles, address=0x0010, i_ready pulse one cycle later with i_data=0x1234, d_ready stays 0.
- Data write, d_addr=0x0020, d_wdata=0xBEEF, ackOutput after 1 cycle -> writeM=1 with mem_wdata=0xBEEF, d_ready pulse, d_rdata unchanged, readM never asserted.
- i_req and d_req held continuously, with data re-requesting after each ready -> grant order D,D,D,D,I,D,D,D,D,I.
- Read with memory silent -> readM held exactly 15 cycles, then d_ready and bus_err pulse together, d_rdata=0x0000, next request serviced normally.
- Reset asserted mid-BUSY -> readM/writeM low after that edge, no ready pulse, streak cleared, next request starts from IDLE.
- ackOutput pulsed during a read, then inputReady 2 cycles later -> completion only on inputReady, with correct data captured.
